mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Host-side initiator for the 8x8 memory array: accepts single read/write requests over a
//   valid/ready handshake and sequences the array's address/op/select/data pins (setup, strobe, hold).
//   It also captures read data and returns one response per request over a second valid/ready handshake.
//   Sits between the host/test logic and the memory module; one request outstanding at a time.
// PARAMETERS
//   ADDR_W         3   address width (8 words)
//   DATA_W         8   word width
//   ACCESS_CYCLES  2   cycles mem_select is held high per access; legal range >= 1
// PORTS
//   clk          in   1        system clock, all logic on rising edge
//   rst          in   1        synchronous, active-high reset
//   req_valid    in   1        host request present
//   req_ready    out  1        controller can accept request (high only in IDLE)
//   req_we       in   1        1 = write, 0 = read
//   req_addr     in   ADDR_W   word address
//   req_wdata    in   DATA_W   write data (ignored for reads)
//   rsp_valid    out  1        response present
//   rsp_ready    in   1        host consumes response
//   rsp_we       out  1        echo of the request's req_we
//   rsp_rdata    out  DATA_W   read data; 0 for write responses
//   mem_adr      out  ADDR_W   to memory address pins
//   mem_op       out  1        to memory op pin: 1 = write, 0 = read
//   mem_select   out  1        to memory select/valid pin (decoder enable)
//   mem_wdata    out  DATA_W   to memory data-in pins
//   mem_rdata    in   DATA_W   from memory data-out pins (OR of cell outputs)
// BEHAVIOUR
//   Reset: state=IDLE, strobe counter=0, latched regs=0; all outputs 0 except req_ready=1 in IDLE.
//   All outputs are registered or decoded from state; no combinational path from req_* / rsp_ready.
//   FSM (1 state per cycle unless stated):
//     IDLE    req_ready=1, mem_select=0, mem_op=0. On req_valid&req_ready: latch we/addr/wdata -> SETUP.
//     SETUP   mem_adr/mem_op/mem_wdata driven from latched regs, mem_select=0 -> STROBE.
//     STROBE  mem_select=1 for exactly ACCESS_CYCLES cycles (counter 0..ACCESS_CYCLES-1).
//             On the last STROBE cycle, for reads, register mem_rdata into rsp_rdata -> HOLD.
//     HOLD    mem_select=0; adr/op/wdata still held -> RESP.
//     RESP    rsp_valid=1, rsp_we/rsp_rdata stable; on rsp_ready -> IDLE (rsp_valid drops next cycle).
//   mem_adr, mem_op, mem_wdata never change while mem_select=1, nor in the cycle before or after it.
//   In IDLE mem_op returns to 0; mem_adr/mem_wdata hold last values.
//   Latency: accept edge at cycle 0 -> rsp_valid high from cycle 3+ACCESS_CYCLES (5 at default).
//   Throughput: one request per 4+ACCESS_CYCLES cycles with rsp_ready tied high.
//   Write responses: rsp_rdata = 0, rsp_we = 1; read responses: rsp_we = 0.
//   req_* changes after acceptance have no effect; req_valid outside IDLE is not accepted (req_ready=0).
//   Backpressure: in RESP with rsp_ready=0, rsp_* hold indefinitely, no new request accepted.
//   Address 0 and ADDR_W-max (7) have no special handling; no wrap logic, address passed verbatim.
//   Reset mid-operation (any state): mem_select=0 and rsp_valid=0 on the next cycle, request dropped,
//     no response issued; controller re-enters IDLE and the next request behaves normally.
// TESTING (memory behavioural model on mem_* pins; ACCESS_CYCLES=2)
//   1 rst high 2 cycles then low -> all outputs 0, req_ready=1, mem_select=0.
//   2 write addr=5 data=0xA5 -> mem_select high exactly 2 cycles with mem_adr=5, mem_op=1,
//     mem_wdata=0xA5 stable SETUP..HOLD; rsp_valid at cycle 5, rsp_we=1, rsp_rdata=0x00.
//   3 read addr=5 after test 2 -> mem_op=0 during strobe; rsp_rdata=0xA5, rsp_we=0.
//   4 rsp_ready=0 for 10 cycles in RESP, req_valid held high -> rsp_valid/rsp_rdata stable,
//     req_ready=0, second request accepted only after rsp_ready handshake.
//   5 write addr i data 0x11*i for i=0..7, then read all -> every read returns 0x11*i (incl. addr 0 and 7).
//   6 assert rst during 1st STROBE cycle of a write to addr 3 -> mem_select=0 next cycle,
//     no rsp_valid; following read of addr 2 completes with correct data.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Host-side request/response handshake bundle for the memory access controller.
// The host drives requests and consumes responses (master); the controller is the slave.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding initiator for the 8x8 memory array: sequences setup, strobe and hold on the
// array pins and returns one registered response per accepted request.
//
// state  | meaning
// IDLE   | req_ready high, mem_op low, waiting for a request
// SETUP  | latched adr/op/wdata on the pins, select still low
// STROBE | mem_select high for ACCESS_CYCLES cycles, read data captured on the last one
// HOLD   | select low, pins still held
// RESP   | rsp_valid high until the host takes it
module mem_access_ctrl #(
  parameter int ADDR_W        = 3,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  host,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_op,
  output logic              mem_select,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_we_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign host.req_ready = req_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_we    = rsp_we_q;
  assign host.rsp_rdata = rsp_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      mem_adr     <= '0;
      mem_op      <= 1'b0;
      mem_select  <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The pin registers double as the request latch, so later req_* changes are ignored.
          if (host.req_valid && req_ready_q) begin
            mem_adr     <= host.req_addr;
            mem_op      <= host.req_we;
            mem_wdata   <= host.req_wdata;
            req_ready_q <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          mem_select <= 1'b1;
          cnt        <= '0;
          state      <= STROBE;
        end
        STROBE: begin
          if (cnt == CNT_LAST) begin
            mem_select  <= 1'b0;
            cnt         <= '0;
            rsp_rdata_q <= mem_op ? '0 : mem_rdata;
            state       <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          rsp_valid_q <= 1'b1;
          rsp_we_q    <= mem_op;
          state       <= RESP;
        end
        RESP: begin
          if (host.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            mem_op      <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          mem_select  <= 1'b0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural 8x8 memory on the mem_* pins, reference array and
// response scoreboard; each scenario task does its own comparisons.
module tb_mem_access_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int AC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_clr = 1'b1;
  logic [AW-1:0] mem_adr;
  logic          mem_op;
  logic          mem_select;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (ifc),
    .mem_adr    (mem_adr),
    .mem_op     (mem_op),
    .mem_select (mem_select),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_arr [8];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem_arr[i] <= '0;
    end else if (mem_select && mem_op) begin
      mem_arr[mem_adr] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_select && !mem_op) ? mem_arr[mem_adr] : '0;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [8];
  int            n_pass = 0;
  int            n_total = 0;
  int            sel_cnt, pins_bad, rsp_lat;
  logic          setup_sel;

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int   guard;
    exp_t e;
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_we    = we;
    ifc.req_addr  = addr;
    ifc.req_wdata = wd;
    guard = 0;
    while (ifc.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_total++;
      $display("FAIL accept_timeout: req_ready=%b required 1", ifc.req_ready);
      ifc.req_valid = 1'b0;
      rsp_lat = -1;
      return;
    end
    e.we    = we;
    e.rdata = we ? '0 : ref_mem[addr];
    if (we) ref_mem[addr] = wd;
    exp_q.push_back(e);
    @(negedge clk);
    // Scramble the request fields to show they were latched at acceptance.
    ifc.req_valid = 1'b0;
    ifc.req_we    = ~we;
    ifc.req_addr  = ~addr;
    ifc.req_wdata = ~wd;
    sel_cnt   = 0;
    pins_bad  = 0;
    setup_sel = mem_select;
    rsp_lat   = -1;
    for (int c = 1; c < 20; c++) begin
      if (c > 1) @(negedge clk);
      if (ifc.rsp_valid === 1'b1) begin
        rsp_lat = c;
        break;
      end
      if (mem_select === 1'b1) sel_cnt++;
      if (mem_adr !== addr || mem_op !== we || mem_wdata !== wd) pins_bad++;
    end
  endtask

  task automatic get_rsp(output logic we, output logic [DW-1:0] rd);
    int guard = 0;
    while (ifc.rsp_valid !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    we = ifc.rsp_we;
    rd = ifc.rsp_rdata;
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_we    = 1'b0;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    ifc.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    n_total++;
    if (ifc.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b need 1", ifc.req_ready);
    else n_pass++;
    n_total++;
    if (mem_select !== 1'b0) $display("FAIL reset_mem_select: got %b need 0", mem_select);
    else n_pass++;
    n_total++;
    if (ifc.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b need 0", ifc.rsp_valid);
    else n_pass++;
    n_total++;
    if ({mem_adr, mem_op, mem_wdata, ifc.rsp_we, ifc.rsp_rdata} !== '0)
      $display("FAIL reset_outputs: adr=%h op=%b wdata=%h rsp_we=%b rdata=%h need all 0",
               mem_adr, mem_op, mem_wdata, ifc.rsp_we, ifc.rsp_rdata);
    else n_pass++;
  endtask

  task automatic test_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input string name);
    exp_t          e;
    logic          got_we;
    logic [DW-1:0] got_rd;
    issue(we, addr, wd);
    n_total++;
    if (sel_cnt !== AC || setup_sel !== 1'b0)
      $display("FAIL %s_strobe: select cycles=%0d setup_sel=%b need %0d and 0", name, sel_cnt, setup_sel, AC);
    else n_pass++;
    n_total++;
    if (pins_bad !== 0) $display("FAIL %s_pins: unstable cycles=%0d need 0", name, pins_bad);
    else n_pass++;
    n_total++;
    if (rsp_lat !== 3 + AC) $display("FAIL %s_latency: got %0d need %0d", name, rsp_lat, 3 + AC);
    else n_pass++;
    pop_exp(e);
    get_rsp(got_we, got_rd);
    n_total++;
    if (got_we !== e.we || got_rd !== e.rdata)
      $display("FAIL %s_rsp: we=%b rdata=%h need we=%b rdata=%h", name, got_we, got_rd, e.we, e.rdata);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    exp_t          e;
    logic          got_we;
    logic [DW-1:0] got_rd, rd0;
    logic          we0;
    int            bad;
    issue(1'b0, 3'd5, 8'h00);
    rd0 = ifc.rsp_rdata;
    we0 = ifc.rsp_we;
    ifc.req_valid = 1'b1;
    ifc.req_we    = 1'b1;
    ifc.req_addr  = 3'd6;
    ifc.req_wdata = 8'h66;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_rdata !== rd0 || ifc.rsp_we !== we0 ||
          ifc.req_ready !== 1'b0 || mem_select !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL bp_hold: disturbed cycles=%0d need 0", bad);
    else n_pass++;
    ifc.req_valid = 1'b0;
    pop_exp(e);
    get_rsp(got_we, got_rd);
    n_total++;
    if (got_we !== e.we || got_rd !== e.rdata)
      $display("FAIL bp_rsp: we=%b rdata=%h need we=%b rdata=%h", got_we, got_rd, e.we, e.rdata);
    else n_pass++;
    n_total++;
    if (ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 1'b1)
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b need 0 and 1", ifc.rsp_valid, ifc.req_ready);
    else n_pass++;
    n_total++;
    if (mem_arr[6] !== 8'h00) $display("FAIL bp_no_accept: mem[6]=%h need 00", mem_arr[6]);
    else n_pass++;
    test_access(1'b1, 3'd6, 8'h66, "bp_second");
  endtask

  task automatic test_sweep();
    exp_t          e;
    logic          got_we;
    logic [DW-1:0] got_rd;
    int            bad;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, AW'(i), DW'(8'h11 * i));
      if (rsp_lat !== 3 + AC || sel_cnt !== AC || pins_bad !== 0) bad++;
      pop_exp(e);
      get_rsp(got_we, got_rd);
      if (got_we !== 1'b1 || got_rd !== 8'h00) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL sweep_writes: bad responses=%0d need 0", bad);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, AW'(i), 8'h5A);
      pop_exp(e);
      get_rsp(got_we, got_rd);
      n_total++;
      if (got_we !== 1'b0 || got_rd !== DW'(8'h11 * i) || got_rd !== e.rdata)
        $display("FAIL sweep_read_%0d: we=%b rdata=%h need we=0 rdata=%h", i, got_we, got_rd, DW'(8'h11 * i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int guard, seen;
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_we    = 1'b1;
    ifc.req_addr  = 3'd3;
    ifc.req_wdata = 8'h77;
    guard = 0;
    while (ifc.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    ifc.req_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (mem_select !== 1'b1) $display("FAIL rstmid_strobe: mem_select=%b need 1", mem_select);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (mem_select !== 1'b0 || ifc.rsp_valid !== 1'b0)
      $display("FAIL rstmid_clear: mem_select=%b rsp_valid=%b need 0 0", mem_select, ifc.rsp_valid);
    else n_pass++;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ifc.rsp_valid === 1'b1 || mem_select === 1'b1) seen++;
    end
    n_total++;
    if (seen !== 0 || ifc.req_ready !== 1'b1)
      $display("FAIL rstmid_dropped: activity cycles=%0d req_ready=%b need 0 and 1", seen, ifc.req_ready);
    else n_pass++;
    test_access(1'b0, 3'd2, 8'h00, "rstmid_read");
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d left need 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    test_reset();
    test_access(1'b1, 3'd5, 8'hA5, "write5");
    test_access(1'b0, 3'd5, 8'h3C, "read5");
    test_backpressure();
    test_sweep();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
